// File: rtl/kim_rr_arb_4to1.sv
// Round-robin arbiter for four burst requesters sharing one 4:1 datapath mux.
// Optional beat limit per grant is compiled in with `define KIM_ARB_BURST_LIMIT_EN.
module kim_rr_arb_4to1 #(
   parameter int MAX_BURST = 16,
   parameter int CNT_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           req_valid,
   input  logic [3:0]           req_last,
   output logic [3:0]           req_ready,
   output logic [1:0]           sel,
   output logic [3:0]           grant,
   output logic                 out_valid,
   output logic                 out_last,
   input  logic                 out_ready,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] beat_cnt,
   output logic                 burst_trunc
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;
   localparam logic [CNT_WIDTH-1:0] CNT_SAT = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [0:0]           state_r, state_nxt_s;
   logic [3:0]           grant_r, grant_nxt_s;
   logic [1:0]           sel_r, sel_nxt_s;
   logic [1:0]           last_gnt_r, last_gnt_nxt_s;
   logic [CNT_WIDTH-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
   logic                 trunc_r, trunc_nxt_s;
   logic                 any_req_s;
   logic [1:0]           pick_s;
   logic                 out_valid_s, out_last_s, accept_s, limit_hit_s, release_s;
   logic [3:0]           req_ready_s;

   // First requester above the previous winner, wrapping 3 -> 0.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
      logic [1:0] idx;
      logic [1:0] res;
      logic       found;
      res   = 2'b00;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx   = last + k[1:0];
         res   = (!found && req[idx]) ? idx : res;
         found = found | req[idx];
      end
      return res;
   endfunction

   assign any_req_s = |req_valid;
   assign pick_s    = rr_pick(req_valid, last_gnt_r);
   assign cnt_inc_s = (cnt_r == CNT_SAT) ? cnt_r : cnt_r + CNT_ONE;

   // Beat handshake through the granted requester; everything is quiet while idle.
   always_comb begin
      out_valid_s = 1'b0;
      out_last_s  = 1'b0;
      req_ready_s = 4'b0000;
      if (state_r == ST_BURST) begin
         out_valid_s = req_valid[sel_r];
         out_last_s  = req_last[sel_r];
         req_ready_s = {3'b000, out_ready} << sel_r;
      end else begin
         out_valid_s = 1'b0;
         out_last_s  = 1'b0;
         req_ready_s = 4'b0000;
      end
   end

   assign accept_s = out_valid_s & out_ready;

`ifdef KIM_ARB_BURST_LIMIT_EN
   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_BURST);
   assign limit_hit_s = accept_s & ~out_last_s & (cnt_inc_s == MAX_CNT);
`else
   logic [31:0] unused_max_burst_s;
   assign unused_max_burst_s = 32'(MAX_BURST);
   assign limit_hit_s        = 1'b0;
`endif

   assign release_s = accept_s & (out_last_s | limit_hit_s);

   // Next-state: arbitrate in IDLE, count beats and release in BURST; sel is left alone on release.
   always_comb begin
      state_nxt_s    = state_r;
      grant_nxt_s    = grant_r;
      sel_nxt_s      = sel_r;
      last_gnt_nxt_s = last_gnt_r;
      cnt_nxt_s      = cnt_r;
      trunc_nxt_s    = trunc_r | limit_hit_s;
      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               state_nxt_s = ST_BURST;
               grant_nxt_s = 4'b0001 << pick_s;
               sel_nxt_s   = pick_s;
               cnt_nxt_s   = {CNT_WIDTH{1'b0}};
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (accept_s) begin
               cnt_nxt_s = cnt_inc_s;
            end else begin
               cnt_nxt_s = cnt_r;
            end
            if (release_s) begin
               state_nxt_s    = ST_IDLE;
               grant_nxt_s    = 4'b0000;
               last_gnt_nxt_s = sel_r;
            end else begin
               state_nxt_s = ST_BURST;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            grant_nxt_s = 4'b0000;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         grant_r    <= 4'b0000;
         sel_r      <= 2'b00;
         last_gnt_r <= 2'b11;
         cnt_r      <= {CNT_WIDTH{1'b0}};
         trunc_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         grant_r    <= grant_nxt_s;
         sel_r      <= sel_nxt_s;
         last_gnt_r <= last_gnt_nxt_s;
         cnt_r      <= cnt_nxt_s;
         trunc_r    <= trunc_nxt_s;
      end
   end

   assign grant       = grant_r;
   assign sel         = sel_r;
   assign busy        = (state_r == ST_BURST);
   assign beat_cnt    = cnt_r;
   assign burst_trunc = trunc_r;
   assign out_valid   = out_valid_s;
   assign out_last    = out_last_s;
   assign req_ready   = req_ready_s;

endmodule

// File: tb/tb_kim_rr_arb_4to1.sv
// Directed testbench for kim_rr_arb_4to1 with hand-computed expectations.
module tb_kim_rr_arb_4to1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req_valid = 4'b0000;
   logic [3:0] req_last = 4'b0000;
   logic [3:0] req_ready;
   logic [1:0] sel;
   logic [3:0] grant;
   logic       out_valid;
   logic       out_last;
   logic       out_ready = 1'b0;
   logic       busy;
   logic [4:0] beat_cnt;
   logic       burst_trunc;

   int n_cmp = 0;
   int n_err = 0;

   kim_rr_arb_4to1 #(.MAX_BURST(4), .CNT_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
      .req_ready(req_ready), .sel(sel), .grant(grant), .out_valid(out_valid),
      .out_last(out_last), .out_ready(out_ready), .busy(busy),
      .beat_cnt(beat_cnt), .burst_trunc(burst_trunc)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = 4'b0000;
      req_last  = 4'b0000;
      out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
      n_cmp++; if (sel !== 2'b00) begin n_err++; $display("FAIL reset_sel: got %b want 00", sel); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (beat_cnt !== 5'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", beat_cnt); end
      n_cmp++; if (burst_trunc !== 1'b0) begin n_err++; $display("FAIL reset_trunc: got %b want 0", burst_trunc); end
      n_cmp++; if ({req_ready, out_valid, out_last} !== 6'b000000) begin n_err++; $display("FAIL reset_comb: got %b want 000000", {req_ready, out_valid, out_last}); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fairness();
      logic [3:0] exp_g [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      req_valid = 4'hF;
      req_last  = 4'hF;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_cmp++; if (grant !== exp_g[k] || busy !== 1'b1) begin n_err++; $display("FAIL fair_grant%0d: got %b busy %b want %b busy 1", k, grant, busy, exp_g[k]); end
         n_cmp++; if (req_ready !== exp_g[k] || out_last !== 1'b1) begin n_err++; $display("FAIL fair_ready%0d: got %b last %b want %b last 1", k, req_ready, out_last, exp_g[k]); end
         tick();
         n_cmp++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL fair_idle%0d: got %b busy %b want 0000 busy 0", k, grant, busy); end
      end
      req_valid = 4'b0000;
      req_last  = 4'b0000;
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fair_stay_idle: got %b want 0", busy); end
   endtask

   task automatic test_single_burst();
      do_reset();
      req_valid = 4'b0010;
      out_ready = 1'b1;
      tick();
      n_cmp++; if (grant !== 4'b0010 || sel !== 2'b01) begin n_err++; $display("FAIL single_grant: got %b/%b want 0010/01", grant, sel); end
      for (int b = 1; b <= 3; b++) begin
         req_last = (b == 3) ? 4'b0010 : 4'b0000;
         #1;
         n_cmp++; if (req_ready !== 4'b0010 || out_valid !== 1'b1) begin n_err++; $display("FAIL single_ready%0d: got %b valid %b want 0010 valid 1", b, req_ready, out_valid); end
         tick();
         n_cmp++; if (beat_cnt !== 5'(b)) begin n_err++; $display("FAIL single_cnt%0d: got %0d want %0d", b, beat_cnt, b); end
      end
      req_valid = 4'b0000;
      req_last  = 4'b0000;
      n_cmp++; if (busy !== 1'b0 || grant !== 4'b0000 || sel !== 2'b01) begin n_err++; $display("FAIL single_end: got busy %b grant %b sel %b want 0 0000 01", busy, grant, sel); end
      tick();
      n_cmp++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_err++; $display("FAIL single_idle: got busy %b grant %b want 0 0000", busy, grant); end
   endtask

   task automatic test_backpressure();
      req_valid = 4'b0100;
      out_ready = 1'b1;
      tick();
      n_cmp++; if (grant !== 4'b0100 || sel !== 2'b10) begin n_err++; $display("FAIL bp_grant: got %b/%b want 0100/10", grant, sel); end
      tick();
      n_cmp++; if (beat_cnt !== 5'd1) begin n_err++; $display("FAIL bp_cnt1: got %0d want 1", beat_cnt); end
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready); end
         tick();
         n_cmp++; if (beat_cnt !== 5'd1 || grant !== 4'b0100 || sel !== 2'b10) begin n_err++; $display("FAIL bp_hold%0d: got %0d %b %b want 1 0100 10", c, beat_cnt, grant, sel); end
      end
      out_ready = 1'b1;
      req_last  = 4'b0100;
      tick();
      n_cmp++; if (beat_cnt !== 5'd2 || busy !== 1'b0) begin n_err++; $display("FAIL bp_end: got cnt %0d busy %b want 2 0", beat_cnt, busy); end
      req_valid = 4'b0000;
      req_last  = 4'b0000;
   endtask

   task automatic test_burst_bubble();
      req_valid = 4'b1000;
      out_ready = 1'b1;
      tick();
      n_cmp++; if (grant !== 4'b1000 || sel !== 2'b11) begin n_err++; $display("FAIL bub_grant: got %b/%b want 1000/11", grant, sel); end
      tick();
      req_valid = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (out_valid !== 1'b0 || req_ready !== 4'b1000) begin n_err++; $display("FAIL bub_comb%0d: got valid %b ready %b want 0 1000", c, out_valid, req_ready); end
         tick();
         n_cmp++; if (grant !== 4'b1000 || beat_cnt !== 5'd1) begin n_err++; $display("FAIL bub_hold%0d: got %b cnt %0d want 1000 1", c, grant, beat_cnt); end
      end
      req_valid = 4'b1001;
      req_last  = 4'b1000;
      tick();
      n_cmp++; if (grant !== 4'b0000 || beat_cnt !== 5'd2) begin n_err++; $display("FAIL bub_end: got %b cnt %0d want 0000 2", grant, beat_cnt); end
      req_valid = 4'b0001;
      req_last  = 4'b0001;
      tick();
      n_cmp++; if (grant !== 4'b0001 || sel !== 2'b00) begin n_err++; $display("FAIL bub_next: got %b/%b want 0001/00", grant, sel); end
      tick();
      req_valid = 4'b0000;
      req_last  = 4'b0000;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bub_done: got %b want 0", busy); end
   endtask

   task automatic test_mid_reset();
      req_valid = 4'hF;
      out_ready = 1'b1;
      tick();
      n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL mrst_grant: got %b want 0010", grant); end
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (grant !== 4'b0000 || sel !== 2'b00 || busy !== 1'b0) begin n_err++; $display("FAIL mrst_regs: got %b %b %b want 0000 00 0", grant, sel, busy); end
      n_cmp++; if (beat_cnt !== 5'd0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL mrst_cnt: got %0d %b want 0 0000", beat_cnt, req_ready); end
      req_valid = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_burst_limit();
      int  nb;
      logic exp_tr;
`ifdef KIM_ARB_BURST_LIMIT_EN
      nb = 4; exp_tr = 1'b1;
`else
      nb = 6; exp_tr = 1'b0;
`endif
      req_valid = 4'b1100;
      out_ready = 1'b1;
      tick();
      n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL lim_grant: got %b want 0100", grant); end
      for (int b = 1; b <= nb; b++) begin
         req_last = (!exp_tr && b == nb) ? 4'b0100 : 4'b0000;
         tick();
         n_cmp++; if (beat_cnt !== 5'(b) || busy !== (b < nb)) begin n_err++; $display("FAIL lim_beat%0d: got cnt %0d busy %b want %0d %b", b, beat_cnt, busy, b, b < nb); end
      end
      n_cmp++; if (burst_trunc !== exp_tr || grant !== 4'b0000) begin n_err++; $display("FAIL lim_trunc: got %b grant %b want %b 0000", burst_trunc, grant, exp_tr); end
      req_last = 4'b0000;
      tick();
      n_cmp++; if (grant !== 4'b1000 || sel !== 2'b11 || burst_trunc !== exp_tr) begin n_err++; $display("FAIL lim_next: got %b %b %b want 1000 11 %b", grant, sel, burst_trunc, exp_tr); end
      req_valid = 4'b1000;
      req_last  = 4'b1000;
      tick();
      req_valid = 4'b0000;
      req_last  = 4'b0000;
      n_cmp++; if (busy !== 1'b0 || burst_trunc !== exp_tr) begin n_err++; $display("FAIL lim_sticky: got busy %b trunc %b want 0 %b", busy, burst_trunc, exp_tr); end
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_single_burst();
      test_backpressure();
      test_burst_bubble();
      test_mid_reset();
      test_burst_limit();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/kim_rr_arb_4to1.md
Name: kim_rr_arb_4to1

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 datapath mux between four requesters in the pipelined 32-bit MIPS core.
- Typical use: four masters on a single downstream port, such as instruction fetch, data load/store, debug and DMA sharing a memory bus.
- Grants one requester at a time, drives the mux `sel`, and holds the grant for the whole burst (until a `last` beat is accepted).
- Arbitrates only; the data path goes through the existing 4:1 mux using this block's `sel`.

Parameters:
- MAX_BURST, 16, beat limit per grant; used only when the optional feature is compiled in. Legal range 1..2^CNT_WIDTH-1.
- CNT_WIDTH, 5, width of the beat counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  4  per-requester beat valid; bit i = requester i.
- req_last  input  4  per-requester last-beat flag; qualified by req_valid.
- req_ready  output  4  per-requester beat accepted.
- sel  output  2  registered select to the 4:1 mux (00=a/req0 .. 11=d/req3).
- grant  output  4  registered one-hot grant; all-zero when idle.
- out_valid  output  1  downstream beat valid.
- out_last  output  1  downstream last flag.
- out_ready  input  1  downstream ready.
- busy  output  1  high while in state BURST.
- beat_cnt  output  CNT_WIDTH  beats accepted in the current burst.
- burst_trunc  output  1  sticky flag: a burst was truncated.

Behaviour:
- Reset (async assert, sync-safe release):
  - grant=0, sel=2'b00, busy=0, beat_cnt=0, burst_trunc=0.
  - Round-robin pointer last_gnt=2'b11, so req0 has first priority after reset.
  - Comb outputs with grant=0: req_ready=0, out_valid=0, out_last=0.
- States: IDLE, BURST.
- IDLE:
  - If any req_valid is high, pick the first set bit searching from last_gnt+1 upward, wrapping 3->0.
  - On the next edge: register grant (one-hot) and sel, clear beat_cnt, go to BURST.
  - Arbitration latency: req_valid sampled in cycle N; grant/sel valid in N+1; first beat can be accepted in N+1.
  - No valid request: stay in IDLE, no change.
- BURST (combinational, granted index g=sel):
  - out_valid = req_valid[g]; out_last = req_last[g].
  - req_ready[g] = out_ready; all other req_ready bits = 0.
  - Beat accepted = out_valid & out_ready. On an accepted beat, beat_cnt increments, saturating at 2^CNT_WIDTH-1.
  - Accepted beat with out_last=1:
    - Next edge: grant<=0, last_gnt<=g, go to IDLE.
    - sel holds its value (no glitch on the mux).
  - Granted requester drops req_valid mid-burst: grant is held and out_valid=0 (bubble). The grant is never released without a last beat, except via the optional feature.
  - Other requesters' valid/last bits are ignored while in BURST.
- Back-to-back grants always have exactly one IDLE cycle between them.
- Fairness: with all four requesting continuously, grant order is 0,1,2,3,0,...
- Simultaneous events:
  - A last beat accepted in the same cycle as new requests: the new requests are arbitrated in the following IDLE cycle against the updated last_gnt.
  - A single requester alone regains the grant after the one IDLE cycle.
- Reset asserted mid-burst: immediate return to reset values. No partial-burst recovery; requesters must restart.

Optional Feature:
- Macro KIM_ARB_BURST_LIMIT_EN.
- Defined:
  - An accepted beat that makes beat_cnt reach MAX_BURST without out_last releases the grant exactly as a last beat would.
  - burst_trunc is set to 1 and stays set until reset.
  - The truncated requester competes again under the normal round-robin rule.
- Not defined:
  - No limit is applied; bursts end only on a last beat.
  - burst_trunc is tied to 0 and MAX_BURST is unused.

Test Plan:
- Reset: assert rst_n=0 mid-simulation with req_valid=4'hF -> immediately grant=0, sel=00, busy=0, beat_cnt=0, req_ready=0.
- Single burst: req_valid=4'b0010, 3 beats with last on the 3rd, out_ready=1 -> grant=0010 and sel=01 one cycle after request; 3 consecutive req_ready[1] pulses; beat_cnt 1,2,3; IDLE on the 4th cycle after grant.
- Fairness: req_valid=4'hF constantly, every beat last=1 -> grants 0001,0010,0100,1000,0001, each separated by one IDLE cycle.
- Backpressure: during req2's burst, out_ready=0 for 2 cycles -> req_ready=0, beat_cnt holds, grant/sel stay 0100/10.
- Burst bubble: req3 drops req_valid for 3 cycles mid-burst while req0 requests -> grant stays 1000; req0 is granted only after req3's last beat plus one IDLE cycle.
- Feature (KIM_ARB_BURST_LIMIT_EN, MAX_BURST=4): req2 sends a 6-beat burst and req3 is pending -> release after the 4th beat, burst_trunc=1, next grant 1000.
